func_mul_seq: RTL and testbench
===============================

Name: func_mul_seq

Overview:
- Responder end of the functional-unit start/busy handshake. Receives a one-cycle `start_i` with operands `a_bi`/`b_bi` from the CPU-side functional-unit wrapper.
- Computes an unsigned WIDTH×WIDTH → 2·WIDTH product by iterative shift-and-add, one bit per cycle.
- Holds `busy_o` high while computing, then presents the result on `y_bo` and releases `busy_o`.
- Drop-in for the functional-unit compute slot: same port names, widths and handshake timing the initiator expects.

Parameters:
- WIDTH, 32, operand width in bits; the result is 2·WIDTH bits.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  request pulse; sampled only in IDLE.
- a_bi  input  WIDTH  multiplicand; sampled on the edge that accepts start_i.
- b_bi  input  WIDTH  multiplier; sampled on the edge that accepts start_i.
- busy_o  output  1  registered; high while an operation is in progress.
- y_bo  output  2·WIDTH  registered result; holds the last completed product.

Behaviour:
- Reset (async, `rst_i`=1): state=IDLE, `busy_o`=0, `y_bo`=0, internal accumulator/count=0. Reset asserted mid-operation aborts the operation immediately; no result is written.
- States:
  - IDLE: `busy_o`=0.
  - WORK: `busy_o`=1.
- IDLE → WORK on a rising edge with `start_i`=1. On that edge:
  - latch `a_bi` into the multiplicand register;
  - load the product register as {hi=0, lo=`b_bi`};
  - set count=0;
  - set `busy_o`<=1.
- WORK, each edge, one iteration:
  - sum = hi + (lo[0] ? a : 0), computed WIDTH+1 bits wide so the carry is kept;
  - {hi, lo} <= {sum, lo} >> 1, a 2·WIDTH+1-bit right shift;
  - count <= count+1.
- On the iteration edge where count==WIDTH-1 (the final iteration):
  - `y_bo` <= the shifted product;
  - `busy_o` <= 0;
  - state <= IDLE.
- Latency: start accepted at edge N → `busy_o` high for exactly WIDTH cycles (edges N..N+WIDTH). `y_bo` is valid and `busy_o`=0 from edge N+WIDTH. For WIDTH=32 this is 32 busy cycles.
- Handshake compatibility:
  - `busy_o` rises on the same edge that samples `start_i`=1. The initiator therefore never sees `start_i`=0 and `busy_o`=0 together before the result is ready.
  - `y_bo` is never updated while `busy_o`=1; it keeps the previous result until the new one is written.
- `start_i` while in WORK: ignored. Operands are not re-sampled and latency is not extended.
- `start_i` held high across completion: the FSM returns to IDLE at edge N+WIDTH and accepts a new operation at edge N+WIDTH+1. This uses the current `a_bi`/`b_bi` and needs one IDLE cycle between operations.
- `a_bi`/`b_bi` changing during WORK: no effect.
- Arithmetic:
  - unsigned only;
  - the full 2·WIDTH result is exact, with no truncation or overflow flag;
  - the carry out of the hi addition must not be lost (all-ones operands case).
- Counter: $clog2(WIDTH) bits; no wrap-around reachable.

Decomposition:
- Shared package (func_pkg): state encoding (FSM_IDLE=1'b0, FSM_WORK=1'b1), default FUNC_WIDTH=32, and a FUNC_LATENCY constant equal to WIDTH for benches.
- No sub-module is natural. The one-bit shift-add step stays inline as a single combinational block next to the FSM.

Test Plan:
- Basic product: reset, then pulse `start_i` with a=6, b=7 → `busy_o`=1 for exactly 32 cycles, then `y_bo`=64'd42 with `busy_o`=0.
- Extremes: a=0xFFFFFFFF, b=0xFFFFFFFF → `y_bo`=0xFFFFFFFE00000001. Then a=0, b=0x12345678 → `y_bo`=0. Then a=0x80000000, b=2 → `y_bo`=0x0000000100000000.
- Hold and ignore: after 6×7, start 3×5 and pulse `start_i` again at cycle 10 with a=9, b=9 → `y_bo` stays 42 during busy, final `y_bo`=15, busy length still 32.
- Initiator timing: drive `start_i` high for exactly 2 cycles (the registered pulse the wrapper produces) → only one operation is accepted and `busy_o` is high on the cycle after the first edge.
- Reset mid-op: start a=100, b=100, assert `rst_i` asynchronously at cycle 15 → `busy_o` and `y_bo` drop to 0 immediately. After release, a new start 3×4 → `y_bo`=12 after 32 cycles.
- Random sweep: 1000 random unsigned operand pairs, back-to-back with the minimum one-cycle gap → each `y_bo` equals the reference a·b, and every busy window is exactly WIDTH cycles.

Source files
------------

// File: rtl/func_pkg.sv
// Shared definitions for the functional-unit compute slot: FSM encoding,
// default operand width and the compute latency that initiators/benches rely on.
package func_pkg;

  typedef enum logic {
    FSM_IDLE = 1'b0,
    FSM_WORK = 1'b1
  } fsm_e;

  localparam int FUNC_WIDTH   = 32;
  localparam int FUNC_LATENCY = FUNC_WIDTH;

endpackage

// File: rtl/func_mul_seq.sv
// Unsigned WIDTH x WIDTH -> 2*WIDTH shift-and-add multiplier, one bit per cycle.
// busy_o rises on the edge that accepts start_i; y_bo is written WIDTH edges later.
module func_mul_seq
  import func_pkg::*;
#(
  parameter int WIDTH = FUNC_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_bi,
  input  logic [WIDTH-1:0]     b_bi,
  output logic                 busy_o,
  output logic [2*WIDTH-1:0]   y_bo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  fsm_e                 state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic [2*WIDTH-1:0]   y_q, y_d;

  // Sum keeps the carry out of the hi half; it becomes the MSB after the shift.
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   shifted;

  always_comb begin
    sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
    shifted = {sum, prod_q[WIDTH-1:1]};

    state_d = state_q;
    a_d     = a_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    y_d     = y_q;

    case (state_q)
      FSM_IDLE: begin
        if (start_i) begin
          state_d = FSM_WORK;
          a_d     = a_bi;
          prod_d  = {{WIDTH{1'b0}}, b_bi};
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      FSM_WORK: begin
        prod_d = shifted;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          y_d     = shifted;
          busy_d  = 1'b0;
          state_d = FSM_IDLE;
        end
      end
      default: begin
        state_d = FSM_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FSM_IDLE;
      a_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      y_q     <= y_d;
    end
  end

  assign busy_o = busy_q;
  assign y_bo   = y_q;

endmodule

// File: tb/tb_func_mul_seq.sv
// Directed and random checks of func_mul_seq: products, busy window length,
// result hold during busy, start filtering and asynchronous reset abort.
module tb_func_mul_seq;
  import func_pkg::*;

  localparam int W = FUNC_WIDTH;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           start_i;
  logic [W-1:0]   a_bi;
  logic [W-1:0]   b_bi;
  logic           busy_o;
  logic [2*W-1:0] y_bo;

  int checks = 0;
  int errors = 0;

  func_mul_seq #(.WIDTH(W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .a_bi    (a_bi),
    .b_bi    (b_bi),
    .busy_o  (busy_o),
    .y_bo    (y_bo)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Count edges until busy_o falls, sampling 1 time unit after each edge.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy_o === 1'b1 && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
  endtask

  // One full operation: start pulse for one edge, then busy length and product.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp);
    int n;
    @(negedge clk_i);
    start_i = 1'b1; a_bi = a; b_bi = b;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    if (busy_o !== 1'b1) check({tag, "_busy_rise"}, 64'(busy_o), 64'd1);
    wait_idle(n);
    check({tag, "_busy_len"}, 64'(n), 64'(FUNC_LATENCY));
    check({tag, "_y"}, y_bo, exp);
  endtask

  initial begin
    int n;
    bit y_moved;
    logic [W-1:0] ra, rb;

    rst_i = 1'b1; start_i = 1'b0; a_bi = '0; b_bi = '0;
    #12;
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_y", y_bo, 64'd0);
    @(negedge clk_i); rst_i = 1'b0;

    run_op("basic_6x7", 32'd6, 32'd7, 64'd42);
    run_op("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("zero_a", 32'd0, 32'h1234_5678, 64'd0);
    run_op("msb_x2", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);

    // Restore 42 in y_bo, then check it holds while 3x5 runs and a second start is ignored.
    run_op("basic_again", 32'd6, 32'd7, 64'd42);
    @(negedge clk_i);
    start_i = 1'b1; a_bi = 32'd3; b_bi = 32'd5;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    n = 0; y_moved = 1'b0;
    while (busy_o === 1'b1 && n < 200) begin
      if (y_bo !== 64'd42) y_moved = 1'b1;
      if (n == 9) begin start_i = 1'b1; a_bi = 32'd9; b_bi = 32'd9; end
      if (n == 10) start_i = 1'b0;
      @(posedge clk_i); #1;
      n++;
    end
    check("hold_y_during_busy", 64'(y_moved), 64'd0);
    check("ignore_busy_len", 64'(n), 64'(FUNC_LATENCY));
    check("ignore_y", y_bo, 64'd15);

    // Two-cycle start: only the first edge is accepted.
    @(negedge clk_i);
    start_i = 1'b1; a_bi = 32'd11; b_bi = 32'd13;
    @(posedge clk_i); #1;
    check("two_cyc_busy_rise", 64'(busy_o), 64'd1);
    a_bi = 32'd2; b_bi = 32'd2;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_idle(n);
    check("two_cyc_busy_len", 64'(n + 1), 64'(FUNC_LATENCY));
    check("two_cyc_y", y_bo, 64'd143);
    @(posedge clk_i); #1;
    check("two_cyc_single_accept", 64'(busy_o), 64'd0);

    // Start held across completion: one idle cycle, then a new accept with current operands.
    @(negedge clk_i);
    start_i = 1'b1; a_bi = 32'd4; b_bi = 32'd5;
    @(posedge clk_i); #1;
    wait_idle(n);
    check("held_busy_len", 64'(n), 64'(FUNC_LATENCY));
    check("held_y", y_bo, 64'd20);
    a_bi = 32'd7; b_bi = 32'd8;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("held_reaccept", 64'(busy_o), 64'd1);
    wait_idle(n);
    check("held_second_y", y_bo, 64'd56);

    // Asynchronous reset in mid-operation.
    @(negedge clk_i);
    start_i = 1'b1; a_bi = 32'd100; b_bi = 32'd100;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (14) @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("rst_mid_busy", 64'(busy_o), 64'd0);
    check("rst_mid_y", y_bo, 64'd0);
    @(negedge clk_i); rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("rst_no_restart", 64'(busy_o), 64'd0);
    run_op("after_rst_3x4", 32'd3, 32'd4, 64'd12);

    // Back-to-back random sweep with the minimum idle gap.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) ra = 32'hFFFF_FFFF;
      run_op("rand", ra, rb, 64'(ra) * 64'(rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
